// File: rtl/mbus_arb_pkg.sv
// Shared types and helpers for the master-bus request arbiter.
// Optional statistics counters in the top are enabled with MBUS_ARB_STATS_EN.
package mbus_arb_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_WR       = 3'd1,
    CMD_RD       = 3'd2,
    CMD_WR_BROAD = 3'd3,
    CMD_RD_BROAD = 3'd4
  } mbus_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  // A master is requesting only for the four real bus commands; 5..7 are ignored.
  function automatic logic is_req(input logic [31:0] cmd);
    return (cmd >= 32'(CMD_WR)) && (cmd <= 32'(CMD_RD_BROAD));
  endfunction

  // Encodings 5..7 are undefined commands on the master bus.
  function automatic logic is_bad_cmd(input logic [31:0] cmd);
    return (cmd >= 32'd5) && (cmd <= 32'd7);
  endfunction

  // Saturating increment for 16-bit statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/mbus_rr_picker.sv
// Combinational round-robin picker: scans rr_ptr+1, rr_ptr+2 ... modulo
// N_MASTERS and returns the first active requester.
module mbus_rr_picker #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  // Scan from farthest to nearest so the nearest requester after rr_ptr is written last.
  always_comb begin
    int cand;
    logic [ID_W-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = 0;
    idx         = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = int'(rr_ptr) + k;
      // Explicit wrap keeps the index in range for non-power-of-2 N_MASTERS.
      cand = (cand >= N_MASTERS) ? (cand - N_MASTERS) : cand;
      idx  = ID_W'(cand);
      grant_id    = req[idx] ? idx : grant_id;
      grant_valid = grant_valid | req[idx];
    end
  end

endmodule

// File: rtl/mbus_req_arbiter.sv
// Master-bus front end: round-robin selection of one master request per
// transaction, presented on a valid/ready channel, 1-cycle ack to the winner.
// Define MBUS_ARB_STATS_EN to add per-master grant counters and a bad-command counter.
module mbus_req_arbiter
  import mbus_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int CMD_W     = 3,
  localparam int ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
`ifdef MBUS_ARB_STATS_EN
  output logic [N_MASTERS*STAT_W-1:0]   stat_grant_o,
  output logic [STAT_W-1:0]             stat_bad_cmd_o,
`endif
  input  logic                          rst,
  input  logic [N_MASTERS*CMD_W-1:0]    mbus_cmd_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   mbus_addr_i,
  output logic [N_MASTERS-1:0]          mbus_ack_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CMD_W-1:0]              out_cmd_o,
  output logic [ADDR_W-1:0]             out_addr_o,
  output logic [ID_W-1:0]               out_id_o
);

  arb_state_e           state;
  arb_state_e           next_state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      next_rr;
  logic                 next_valid;
  logic [CMD_W-1:0]     next_cmd;
  logic [ADDR_W-1:0]    next_addr;
  logic [ID_W-1:0]      next_id;
  logic [N_MASTERS-1:0] next_ack;

  logic [N_MASTERS-1:0] req;
  logic [CMD_W-1:0]     cmd_arr  [N_MASTERS];
  logic [ADDR_W-1:0]    addr_arr [N_MASTERS];
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign cmd_arr[g]  = mbus_cmd_i[g*CMD_W +: CMD_W];
    assign addr_arr[g] = mbus_addr_i[g*ADDR_W +: ADDR_W];
    assign req[g]      = is_req(32'(cmd_arr[g]));
  end

  mbus_rr_picker #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_picker (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state and next-output logic; capture registers hold their value unless a grant is taken.
  always_comb begin
    next_state = state;
    next_rr    = rr_ptr;
    next_valid = out_valid_o;
    next_cmd   = out_cmd_o;
    next_addr  = out_addr_o;
    next_id    = out_id_o;
    next_ack   = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = SEND;
          next_valid = 1'b1;
          next_cmd   = cmd_arr[grant_id];
          next_addr  = addr_arr[grant_id];
          next_id    = grant_id;
        end else begin
          next_state = IDLE;
          next_valid = 1'b0;
        end
      end
      SEND: begin
        if (out_ready_i) begin
          next_state         = ACK;
          next_valid         = 1'b0;
          next_rr            = out_id_o;
          next_ack[out_id_o] = 1'b1;
        end else begin
          next_state = SEND;
          next_valid = 1'b1;
        end
      end
      ACK: begin
        next_state = IDLE;
        next_valid = 1'b0;
      end
      default: begin
        next_state = IDLE;
        next_valid = 1'b0;
      end
    endcase
  end

  // State, round-robin pointer and registered outputs; reset starts with master 0 as first winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(N_MASTERS - 1);
      out_valid_o <= 1'b0;
      out_cmd_o   <= '0;
      out_addr_o  <= '0;
      out_id_o    <= '0;
      mbus_ack_o  <= '0;
    end else begin
      state       <= next_state;
      rr_ptr      <= next_rr;
      out_valid_o <= next_valid;
      out_cmd_o   <= next_cmd;
      out_addr_o  <= next_addr;
      out_id_o    <= next_id;
      mbus_ack_o  <= next_ack;
    end
  end

`ifdef MBUS_ARB_STATS_EN
  logic                 hs;
  logic [N_MASTERS-1:0] bad;

  assign hs = (state == SEND) && out_ready_i;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_bad
    assign bad[g] = is_bad_cmd(32'(cmd_arr[g]));
  end

  // Saturating per-master grant counters and the idle bad-command cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_grant_o   <= '0;
      stat_bad_cmd_o <= '0;
    end else begin
      for (int m = 0; m < N_MASTERS; m++) begin
        if (hs && (out_id_o == ID_W'(m))) begin
          stat_grant_o[m*STAT_W +: STAT_W] <= sat_inc16(stat_grant_o[m*STAT_W +: STAT_W]);
        end
      end
      if ((state == IDLE) && (|bad)) begin
        stat_bad_cmd_o <= sat_inc16(stat_bad_cmd_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mbus_req_arbiter.sv
// Directed, scoreboard-based bench for mbus_req_arbiter (N=4, N=3, N=1 instances).
// Statistics checks are compiled in when MBUS_ARB_STATS_EN is defined.
module tb_mbus_req_arbiter;
  import mbus_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rdy;

  logic [11:0]  cmd4;  logic [127:0] addr4; logic [3:0] ack4; logic val4;
  logic [2:0]   ocmd4; logic [31:0]  oaddr4; logic [1:0] oid4;
  logic [8:0]   cmd3;  logic [95:0]  addr3; logic [2:0] ack3; logic val3;
  logic [2:0]   ocmd3; logic [31:0]  oaddr3; logic [1:0] oid3;
  logic [2:0]   cmd1;  logic [31:0]  addr1; logic [0:0] ack1; logic val1;
  logic [2:0]   ocmd1; logic [31:0]  oaddr1; logic [0:0] oid1;
`ifdef MBUS_ARB_STATS_EN
  logic [63:0] sg4; logic [15:0] sb4;
  logic [47:0] sg3; logic [15:0] sb3;
  logic [15:0] sg1; logic [15:0] sb1;
`endif

  mbus_req_arbiter #(.N_MASTERS(4), .ADDR_W(32), .CMD_W(3)) dut (
    .clk(clk),
`ifdef MBUS_ARB_STATS_EN
    .stat_grant_o(sg4), .stat_bad_cmd_o(sb4),
`endif
    .rst(rst), .mbus_cmd_i(cmd4), .mbus_addr_i(addr4), .mbus_ack_o(ack4),
    .out_valid_o(val4), .out_ready_i(rdy), .out_cmd_o(ocmd4), .out_addr_o(oaddr4), .out_id_o(oid4)
  );

  mbus_req_arbiter #(.N_MASTERS(3), .ADDR_W(32), .CMD_W(3)) dut3 (
    .clk(clk),
`ifdef MBUS_ARB_STATS_EN
    .stat_grant_o(sg3), .stat_bad_cmd_o(sb3),
`endif
    .rst(rst), .mbus_cmd_i(cmd3), .mbus_addr_i(addr3), .mbus_ack_o(ack3),
    .out_valid_o(val3), .out_ready_i(rdy), .out_cmd_o(ocmd3), .out_addr_o(oaddr3), .out_id_o(oid3)
  );

  mbus_req_arbiter #(.N_MASTERS(1), .ADDR_W(32), .CMD_W(3)) dut1 (
    .clk(clk),
`ifdef MBUS_ARB_STATS_EN
    .stat_grant_o(sg1), .stat_bad_cmd_o(sb1),
`endif
    .rst(rst), .mbus_cmd_i(cmd1), .mbus_addr_i(addr1), .mbus_ack_o(ack1),
    .out_valid_o(val1), .out_ready_i(rdy), .out_cmd_o(ocmd1), .out_addr_o(oaddr1), .out_id_o(oid1)
  );

  typedef struct {
    int          id;
    logic [2:0]  cmd;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   sel         = 0;

  logic        cur_val;
  logic [2:0]  cur_cmd;
  logic [31:0] cur_addr;
  int          cur_id;
  logic [3:0]  cur_ack;

  // Route the outputs of the instance under test to one set of observation signals.
  always_comb begin
    cur_val  = val4;
    cur_cmd  = ocmd4;
    cur_addr = oaddr4;
    cur_id   = int'(oid4);
    cur_ack  = ack4;
    if (sel == 1) begin
      cur_val  = val3;
      cur_cmd  = ocmd3;
      cur_addr = oaddr3;
      cur_id   = int'(oid3);
      cur_ack  = {1'b0, ack3};
    end else if (sel == 2) begin
      cur_val  = val1;
      cur_cmd  = ocmd1;
      cur_addr = oaddr1;
      cur_id   = int'(oid1);
      cur_ack  = {3'b000, ack1};
    end else begin
      cur_val  = val4;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [2:0] c, input logic [31:0] a);
    case (sel)
      1:       begin cmd3[m*3 +: 3] = c; addr3[m*32 +: 32] = a; end
      2:       begin cmd1 = c; addr1 = a; end
      default: begin cmd4[m*3 +: 3] = c; addr4[m*32 +: 32] = a; end
    endcase
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    cmd4  = '0; addr4 = '0;
    cmd3  = '0; addr3 = '0;
    cmd1  = '0; addr1 = '0;
    sbq.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Wait (bounded) for out_valid, then compare against the oldest scoreboard entry.
  task automatic wait_grant(input string tag, output int id);
    exp_t e;
    int   n;
    n  = 0;
    id = 0;
    while (!cur_val && (n < 50)) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, cur_val, 1);
    chk({tag, "_sb_nonempty"}, (sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e  = sbq.pop_front();
      id = e.id;
      chk({tag, "_id"},   cur_id,   e.id);
      chk({tag, "_cmd"},  cur_cmd,  e.cmd);
      chk({tag, "_addr"}, cur_addr, e.addr);
    end
  endtask

  // Masters re-request after a single NOP cycle following their ack.
  task automatic run_grants(input string tag, input int n_grants, input logic [2:0] c, input logic [31:0] base);
    int id;
    logic [3:0] ea;
    for (int g = 0; g < n_grants; g++) begin
      wait_grant(tag, id);
      tick();
      ea = 4'b0001 << id;
      chk({tag, "_ack"}, cur_ack, ea);
      chk({tag, "_ackcyc_valid"}, cur_val, 0);
      set_req(id, CMD_NOP, 32'h0);
      tick();
      chk({tag, "_ack_single"}, cur_ack, 4'b0000);
      set_req(id, c, base + 32'(id));
    end
  endtask

  initial begin
    int id;
    rst = 1'b0;
    rdy = 1'b1;
    cmd4 = '0; addr4 = '0; cmd3 = '0; addr3 = '0; cmd1 = '0; addr1 = '0;
    tick();
    tick();
    chk("rst_valid", val4, 0);
    chk("rst_ack",   ack4, 0);
    chk("rst_cmd",   ocmd4, 0);
    chk("rst_addr",  oaddr4, 0);
    chk("rst_id",    oid4, 0);
    chk("rst_valid3", val3, 0);
    chk("rst_valid1", val1, 0);

    // Single read from master 2: valid after one cycle, ack one cycle after handshake.
    set_req(2, CMD_RD, 32'h1000);
    tick();
    chk("rst_hold_valid", val4, 0);
    sbq.push_back('{2, CMD_RD, 32'h1000});
    rst = 1'b1;
    tick();
    chk("t1_valid_cycle1", val4, 1);
    wait_grant("t1", id);
    tick();
    chk("t1_ack", ack4, 4'b0100);
    chk("t1_valid_off", val4, 0);
    set_req(2, CMD_NOP, 32'h0);
    tick();
    chk("t1_ack_clear", ack4, 4'b0000);
    chk("t1_idle_valid", val4, 0);

    // All four masters writing continuously: order 0,1,2,3,0.
    do_reset();
    for (int m = 0; m < 4; m++) set_req(m, CMD_WR, 32'h2000 + 32'(m));
    for (int g = 0; g < 5; g++) sbq.push_back('{g % 4, CMD_WR, 32'h2000 + 32'(g % 4)});
    run_grants("rr4", 5, CMD_WR, 32'h2000);
`ifdef MBUS_ARB_STATS_EN
    chk("stat_grant_m0", sg4[15:0], 16'd2);
    chk("stat_grant_m3", sg4[63:48], 16'd1);
`endif

    // Backpressure: outputs frozen while ready is low, even if the master changes address.
    do_reset();
    rdy = 1'b0;
    set_req(1, CMD_RD_BROAD, 32'h3000);
    sbq.push_back('{1, CMD_RD_BROAD, 32'h3000});
    tick();
    wait_grant("bp", id);
    for (int k = 0; k < 5; k++) begin
      set_req(1, CMD_RD_BROAD, 32'h3100 + 32'(k));
      tick();
      chk("bp_valid_held", val4, 1);
      chk("bp_addr_held", oaddr4, 32'h3000);
      chk("bp_no_ack", ack4, 4'b0000);
    end
    rdy = 1'b1;
    tick();
    chk("bp_ack", ack4, 4'b0010);
    set_req(1, CMD_NOP, 32'h0);
    tick();
    chk("bp_ack_clear", ack4, 4'b0000);
`ifdef MBUS_ARB_STATS_EN
    chk("stat_grant_m1", sg4[31:16], 16'd1);
`endif

    // Undefined commands are not requests.
    do_reset();
    set_req(1, 3'd6, 32'h6000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bad6_valid", val4, 0);
      chk("bad6_ack", ack4, 4'b0000);
    end
    set_req(1, 3'd7, 32'h6000);
    tick();
    chk("bad7_valid", val4, 0);
    set_req(1, 3'd5, 32'h6000);
    tick();
    chk("bad5_valid", val4, 0);
`ifdef MBUS_ARB_STATS_EN
    chk("stat_bad_cmd", sb4, 16'd6);
`endif
    set_req(1, CMD_NOP, 32'h0);

    // Reset during SEND of master 3 drops the transaction; master 0 wins first afterwards.
    do_reset();
    rdy = 1'b0;
    set_req(3, CMD_WR, 32'h4000);
    sbq.push_back('{3, CMD_WR, 32'h4000});
    tick();
    wait_grant("rstmid", id);
    rst = 1'b0;
    set_req(0, CMD_RD, 32'h5000);
    tick();
    chk("rstmid_valid", val4, 0);
    chk("rstmid_ack", ack4, 4'b0000);
    chk("rstmid_id", oid4, 0);
    sbq.push_back('{0, CMD_RD, 32'h5000});
    rst = 1'b1;
    tick();
    chk("rstmid_no_ack", ack4, 4'b0000);
    wait_grant("rst_first", id);
    rdy = 1'b1;
    tick();
    chk("rst_first_ack", ack4, 4'b0001);
    set_req(0, CMD_NOP, 32'h0);
    set_req(3, CMD_NOP, 32'h0);
    tick();

    // Non-power-of-2 wrap: N=3 gives 0,1,2,0.
    do_reset();
    sel = 1;
    for (int m = 0; m < 3; m++) set_req(m, CMD_WR_BROAD, 32'h7000 + 32'(m));
    for (int g = 0; g < 4; g++) sbq.push_back('{g % 3, CMD_WR_BROAD, 32'h7000 + 32'(g % 3)});
    run_grants("rr3", 4, CMD_WR_BROAD, 32'h7000);

    // Single master: always id 0.
    do_reset();
    sel = 2;
    set_req(0, CMD_RD, 32'h8000);
    for (int g = 0; g < 3; g++) sbq.push_back('{0, CMD_RD, 32'h8000});
    run_grants("rr1", 3, CMD_RD, 32'h8000);

    sel = 0;
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
